// File: rtl/neo_video_pkg.sv
// Shared constants and helpers for the NeoGeo video path dot generators.
package neo_video_pkg;

    localparam int NEO_BPP    = 4;
    localparam int NEO_PIXELS = 8;
    localparam int NEO_LANES  = 2;

    typedef enum logic {
        FMT_PACKED = 1'b0,
        FMT_PLANAR = 1'b1
    } cr_fmt_e;

    function automatic int group_count(input int pixels, input int lanes);
        return pixels / lanes;
    endfunction

    function automatic bit lanes_divide(input int pixels, input int lanes);
        return (lanes > 0) && ((pixels % lanes) == 0);
    endfunction

    localparam bit NEO_DEFAULTS_OK = lanes_divide(NEO_PIXELS, NEO_LANES);

endpackage

// File: rtl/neo_zmc_dotgen_if.sv
// Load/pixel bus between a sprite fetcher (master) and the dot generator (slave).
interface neo_zmc_dotgen_if
    import neo_video_pkg::*;
#(
    parameter int BPP    = NEO_BPP,
    parameter int PIXELS = NEO_PIXELS,
    parameter int LANES  = NEO_LANES
);
    logic                    CLK_EN;
    logic                    LOAD;
    logic                    H;
    logic [BPP*PIXELS-1:0]   CR;
    logic [LANES*BPP-1:0]    PIX;
    logic [LANES-1:0]        DOT;
    logic                    VALID;
    logic                    READY;
    logic                    OVF;

    modport master (
        output CLK_EN, LOAD, H, CR,
        input  PIX, DOT, VALID, READY, OVF
    );

    modport slave (
        input  CLK_EN, LOAD, H, CR,
        output PIX, DOT, VALID, READY, OVF
    );
endinterface

// File: rtl/neo_zmc_unpack.sv
// Combinational ROM word unpacker: packed or bit-planar CR to a flat pixel array
// (pixel i at pix[i*BPP +: BPP]).
module neo_zmc_unpack
    import neo_video_pkg::*;
#(
    parameter int BPP    = NEO_BPP,
    parameter int PIXELS = NEO_PIXELS,
    parameter int PLANAR = 1
) (
    input  logic [BPP*PIXELS-1:0] cr,
    output logic [BPP*PIXELS-1:0] pix
);
    localparam cr_fmt_e FMT = (PLANAR != 0) ? FMT_PLANAR : FMT_PACKED;

    always_comb begin
        pix = '0;
        for (int i = 0; i < PIXELS; i++) begin
            for (int p = 0; p < BPP; p++) begin
                if (FMT == FMT_PLANAR) begin
                    pix[i*BPP + p] = cr[p*PIXELS + i];
                end else begin
                    pix[i*BPP + p] = cr[i*BPP + p];
                end
            end
        end
    end
endmodule

// File: rtl/neo_zmc_dotgen.sv
// Dot generator: one pending ROM word behind an active shift register, emitting
// LANES pixels per enabled cycle with seamless word chaining and sticky overflow.
module neo_zmc_dotgen
    import neo_video_pkg::*;
#(
    parameter int BPP    = NEO_BPP,
    parameter int PIXELS = NEO_PIXELS,
    parameter int LANES  = NEO_LANES,
    parameter int PLANAR = 1,
    parameter int TRANSP = 0
) (
    input  logic             CLK,
    input  logic             nRESET,
    neo_zmc_dotgen_if.slave  bus
);
    localparam int G     = group_count(PIXELS, LANES);
    localparam int W     = BPP * PIXELS;
    localparam int GW    = LANES * BPP;
    localparam int CNT_W = $clog2(G + 1);
    localparam logic [BPP-1:0] TRANSP_PIX = BPP'(TRANSP);

    if (!lanes_divide(PIXELS, LANES)) begin : g_cfg_check
        $error("neo_zmc_dotgen: PIXELS must be a multiple of LANES");
    end

    logic [W-1:0]     unpacked;
    logic [W-1:0]     ordered;
    logic [GW-1:0]    grp;
    logic             emit;

    logic [W-1:0]     pend_q, pend_d;
    logic             pend_v_q, pend_v_d;
    logic [W-1:0]     act_q, act_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [GW-1:0]    pix_q, pix_d;
    logic [LANES-1:0] dot_q, dot_d;
    logic             valid_q, valid_d;
    logic             ready_q, ready_d;
    logic             ovf_q, ovf_d;

    neo_zmc_unpack #(
        .BPP    (BPP),
        .PIXELS (PIXELS),
        .PLANAR (PLANAR)
    ) u_unpack (
        .cr  (bus.CR),
        .pix (unpacked)
    );

    // Flip is applied at capture so the active register always shifts out lane order.
    always_comb begin
        ordered = '0;
        for (int i = 0; i < PIXELS; i++) begin
            if (bus.H) begin
                ordered[i*BPP +: BPP] = unpacked[(PIXELS-1-i)*BPP +: BPP];
            end else begin
                ordered[i*BPP +: BPP] = unpacked[i*BPP +: BPP];
            end
        end
    end

    always_comb begin
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        act_d    = act_q;
        cnt_d    = cnt_q;
        pix_d    = pix_q;
        dot_d    = dot_q;
        valid_d  = valid_q;
        ovf_d    = ovf_q;
        grp      = '0;
        emit     = 1'b0;

        if (bus.CLK_EN) begin
            if (cnt_q != '0) begin
                grp   = act_q[GW-1:0];
                act_d = act_q >> GW;
                cnt_d = cnt_q - CNT_W'(1);
                emit  = 1'b1;
            end else if (pend_v_q) begin
                // Transfer and emit group 0 on the same edge; no bubble between words.
                grp      = pend_q[GW-1:0];
                act_d    = pend_q >> GW;
                cnt_d    = CNT_W'(G - 1);
                pend_v_d = 1'b0;
                emit     = 1'b1;
            end else begin
                valid_d = 1'b0;
                pix_d   = '0;
                dot_d   = '0;
            end
        end

        if (emit) begin
            pix_d   = grp;
            valid_d = 1'b1;
            for (int l = 0; l < LANES; l++) begin
                dot_d[l] = (grp[l*BPP +: BPP] != TRANSP_PIX);
            end
        end

        // pend_v_d is already cleared when the old word leaves this edge.
        if (bus.LOAD) begin
            if (!pend_v_d) begin
                pend_d   = ordered;
                pend_v_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end

        ready_d = !pend_v_d;
    end

    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            pend_v_q <= 1'b0;
            cnt_q    <= '0;
            pix_q    <= '0;
            dot_q    <= '0;
            valid_q  <= 1'b0;
            ready_q  <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            pend_v_q <= pend_v_d;
            cnt_q    <= cnt_d;
            pix_q    <= pix_d;
            dot_q    <= dot_d;
            valid_q  <= valid_d;
            ready_q  <= ready_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge CLK) begin
        pend_q <= pend_d;
        act_q  <= act_d;
    end

    assign bus.PIX   = pix_q;
    assign bus.DOT   = dot_q;
    assign bus.VALID = valid_q;
    assign bus.READY = ready_q;
    assign bus.OVF   = ovf_q;

endmodule

// File: tb/tb_neo_zmc_dotgen.sv
// Bench for neo_zmc_dotgen: packed and planar instances driven in lock-step,
// checked against a word/group-level reference model plus spec vectors.
module tb_neo_zmc_dotgen;
    import neo_video_pkg::*;

    localparam int G = 4;

    logic        CLK = 1'b0;
    logic        nRESET;
    logic        clk_en, load, h;
    logic [31:0] cr;

    int n_checks = 0;
    int n_err    = 0;

    always #5 CLK = ~CLK;

    neo_zmc_dotgen_if #(.BPP(4), .PIXELS(8), .LANES(2)) if_pk ();
    neo_zmc_dotgen_if #(.BPP(4), .PIXELS(8), .LANES(2)) if_pl ();

    assign if_pk.CLK_EN = clk_en;
    assign if_pk.LOAD   = load;
    assign if_pk.H      = h;
    assign if_pk.CR     = cr;
    assign if_pl.CLK_EN = clk_en;
    assign if_pl.LOAD   = load;
    assign if_pl.H      = h;
    assign if_pl.CR     = cr;

    neo_zmc_dotgen #(.BPP(4), .PIXELS(8), .LANES(2), .PLANAR(0), .TRANSP(0)) dut_pk (
        .CLK    (CLK),
        .nRESET (nRESET),
        .bus    (if_pk.slave)
    );

    neo_zmc_dotgen #(.BPP(4), .PIXELS(8), .LANES(2), .PLANAR(1), .TRANSP(0)) dut_pl (
        .CLK    (CLK),
        .nRESET (nRESET),
        .bus    (if_pl.slave)
    );

    // Reference model: words and group indices.
    bit          m_pend_v = 1'b0;
    logic [31:0] m_pend_cr = '0;
    bit          m_pend_h = 1'b0;
    logic [31:0] m_act_cr = '0;
    bit          m_act_h = 1'b0;
    int          m_act_next = G;
    bit          e_valid = 1'b0;
    bit          e_ready = 1'b1;
    bit          e_ovf = 1'b0;
    logic [31:0] e_cr = '0;
    bit          e_h = 1'b0;
    int          e_g = 0;

    function automatic logic [3:0] pixel_of(input logic [31:0] w, input int i, input bit planar);
        logic [3:0] v;
        for (int p = 0; p < 4; p++) v[p] = planar ? w[p*8 + i] : w[i*4 + p];
        return v;
    endfunction

    function automatic logic [7:0] group_of(input logic [31:0] w, input bit flip, input bit planar, input int g);
        logic [7:0] r;
        int idx;
        r = '0;
        for (int l = 0; l < 2; l++) begin
            idx = g*2 + l;
            if (flip) idx = 7 - idx;
            r[l*4 +: 4] = pixel_of(w, idx, planar);
        end
        return r;
    endfunction

    function automatic logic [1:0] dot_of(input logic [7:0] grp);
        logic [1:0] d;
        for (int l = 0; l < 2; l++) d[l] = (grp[l*4 +: 4] != 4'd0);
        return d;
    endfunction

    task automatic model_edge();
        if (!nRESET) begin
            m_pend_v = 1'b0; m_act_next = G;
            e_valid = 1'b0; e_ready = 1'b1; e_ovf = 1'b0;
            return;
        end
        if (clk_en) begin
            if (m_act_next < G) begin
                e_cr = m_act_cr; e_h = m_act_h; e_g = m_act_next;
                m_act_next++; e_valid = 1'b1;
            end else if (m_pend_v) begin
                m_act_cr = m_pend_cr; m_act_h = m_pend_h; m_pend_v = 1'b0;
                e_cr = m_act_cr; e_h = m_act_h; e_g = 0;
                m_act_next = 1; e_valid = 1'b1;
            end else begin
                e_valid = 1'b0;
            end
        end
        if (load) begin
            if (!m_pend_v) begin
                m_pend_cr = cr; m_pend_h = h; m_pend_v = 1'b1;
            end else begin
                e_ovf = 1'b1;
            end
        end
        e_ready = !m_pend_v;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_dut(input string tag, input bit planar, input logic [7:0] pix,
                             input logic [1:0] dot, input logic valid, input logic ready, input logic ovf);
        logic [7:0] ep;
        ep = e_valid ? group_of(e_cr, e_h, planar, e_g) : 8'h00;
        check({tag, "_pix"},   32'(pix),   32'(ep));
        check({tag, "_dot"},   32'(dot),   32'(e_valid ? dot_of(ep) : 2'b00));
        check({tag, "_valid"}, 32'(valid), 32'(e_valid));
        check({tag, "_ready"}, 32'(ready), 32'(e_ready));
        check({tag, "_ovf"},   32'(ovf),   32'(e_ovf));
    endtask

    task automatic step();
        model_edge();
        @(posedge CLK);
        #1;
        check_dut("pk", 1'b0, if_pk.PIX, if_pk.DOT, if_pk.VALID, if_pk.READY, if_pk.OVF);
        check_dut("pl", 1'b1, if_pl.PIX, if_pl.DOT, if_pl.VALID, if_pl.READY, if_pl.OVF);
    endtask

    task automatic do_reset();
        nRESET = 1'b0; load = 1'b0; clk_en = 1'b0;
        step();
        nRESET = 1'b1;
    endtask

    typedef struct packed {
        bit          planar;
        logic [31:0] cr;
        bit          h;
        logic [31:0] pix;   // group g in bits [g*8 +: 8]
        logic [7:0]  dot;   // group g in bits [g*2 +: 2]
    } vec_t;

    vec_t vecs [4];

    initial begin
        logic [7:0] p;
        logic [1:0] d;
        logic       v;
        int         vcnt;

        vecs[0] = '{planar: 1'b0, cr: 32'h76543210, h: 1'b0, pix: 32'h76543210, dot: 8'b11111110};
        vecs[1] = '{planar: 1'b0, cr: 32'h76543210, h: 1'b1, pix: 32'h01234567, dot: 8'b01111111};
        vecs[2] = '{planar: 1'b1, cr: 32'h000000FF, h: 1'b0, pix: 32'h11111111, dot: 8'hFF};
        vecs[3] = '{planar: 1'b1, cr: 32'h0000FF00, h: 1'b0, pix: 32'h22222222, dot: 8'hFF};

        nRESET = 1'b0; clk_en = 1'b0; load = 1'b0; h = 1'b0; cr = '0;
        do_reset();
        check("rst_valid", 32'(if_pk.VALID), 32'd0);
        check("rst_ready", 32'(if_pk.READY), 32'd1);
        check("rst_ovf",   32'(if_pk.OVF),   32'd0);

        // Spec vectors: load with CLK_EN low, then stream the word.
        for (int vi = 0; vi < 4; vi++) begin
            do_reset();
            cr = vecs[vi].cr; h = vecs[vi].h; load = 1'b1;
            step();
            check("tbl_ready_after_load", 32'(if_pk.READY), 32'd0);
            load = 1'b0; clk_en = 1'b1;
            for (int g = 0; g < G; g++) begin
                step();
                p = vecs[vi].planar ? if_pl.PIX : if_pk.PIX;
                d = vecs[vi].planar ? if_pl.DOT : if_pk.DOT;
                v = vecs[vi].planar ? if_pl.VALID : if_pk.VALID;
                check("tbl_pix",   32'(p), 32'(vecs[vi].pix[g*8 +: 8]));
                check("tbl_dot",   32'(d), 32'(vecs[vi].dot[g*2 +: 2]));
                check("tbl_valid", 32'(v), 32'd1);
            end
            step();
            p = vecs[vi].planar ? if_pl.PIX : if_pk.PIX;
            v = vecs[vi].planar ? if_pl.VALID : if_pk.VALID;
            check("tbl_valid_end", 32'(v), 32'd0);
            check("tbl_pix_end",   32'(p), 32'd0);
        end

        // Back-to-back words: second LOAD while the first is active.
        do_reset();
        clk_en = 1'b1; h = 1'b0; cr = 32'h76543210; load = 1'b1;
        step();
        check("chain_ready_load_a", 32'(if_pk.READY), 32'd0);
        vcnt = 0;
        for (int e = 2; e <= 9; e++) begin
            if (e == 3) begin load = 1'b1; cr = 32'hFEDCBA98; end
            else load = 1'b0;
            step();
            if (if_pk.VALID) vcnt++;
            if (e == 5) check("chain_ready_pend_b", 32'(if_pk.READY), 32'd0);
            if (e == 6) begin
                check("chain_ready_xfer_b", 32'(if_pk.READY), 32'd1);
                check("chain_b_g0", 32'(if_pk.PIX), 32'h98);
            end
        end
        check("chain_valid_count", 32'(vcnt), 32'd8);
        step();
        check("chain_valid_end", 32'(if_pk.VALID), 32'd0);

        // Overflow: two LOADs with CLK_EN low.
        do_reset();
        clk_en = 1'b0; cr = 32'h12345678; load = 1'b1;
        step();
        check("ovf_first_ready", 32'(if_pk.READY), 32'd0);
        check("ovf_first_ovf",   32'(if_pk.OVF),   32'd0);
        cr = 32'h87654321;
        step();
        check("ovf_set", 32'(if_pk.OVF), 32'd1);
        load = 1'b0; clk_en = 1'b1;
        repeat (6) step();
        check("ovf_sticky", 32'(if_pk.OVF), 32'd1);
        check("ovf_kept_first_word", 32'(if_pk.VALID), 32'd0);
        nRESET = 1'b0;
        step();
        check("ovf_cleared", 32'(if_pk.OVF), 32'd0);
        nRESET = 1'b1;

        // Reset in the middle of a word.
        do_reset();
        clk_en = 1'b1; h = 1'b0; cr = 32'h76543210; load = 1'b1;
        step();
        load = 1'b0;
        step();
        step();
        check("mid_g1", 32'(if_pk.PIX), 32'h32);
        nRESET = 1'b0;
        step();
        check("mid_rst_valid", 32'(if_pk.VALID), 32'd0);
        check("mid_rst_pix",   32'(if_pk.PIX),   32'd0);
        check("mid_rst_ready", 32'(if_pk.READY), 32'd1);
        check("mid_rst_ovf",   32'(if_pk.OVF),   32'd0);
        nRESET = 1'b1; load = 1'b1;
        step();
        load = 1'b0;
        step();
        check("mid_restart_g0", 32'(if_pk.PIX), 32'h10);
        step();
        check("mid_restart_g1", 32'(if_pk.PIX), 32'h32);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            nRESET = ($urandom % 64) != 0;
            clk_en = ($urandom % 4) != 0;
            load   = ($urandom % 3) == 0;
            h      = 1'($urandom % 2);
            cr     = $urandom;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
